// File: rtl/mux_4to1.sv
// rtl/mux_4to1.sv - registered 4:1 lane selector with capture-valid flag
// Output and valid flag come straight from flops; en gates capture, valid is per-edge.
module mux_4to1 #(
  parameter int          WIDTH     = 1,
  parameter logic [63:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         sel,
  input  logic [4*WIDTH-1:0] d,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid
);

  localparam logic [WIDTH-1:0] RST_Y = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    case (sel)
      2'd0: sel_data = d[0*WIDTH +: WIDTH];
      2'd1: sel_data = d[1*WIDTH +: WIDTH];
      2'd2: sel_data = d[2*WIDTH +: WIDTH];
      2'd3: sel_data = d[3*WIDTH +: WIDTH];
      default: sel_data = '0;
    endcase
  end

  // y holds through disabled edges; y_valid only reports the last edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= RST_Y;
      y_valid <= 1'b0;
    end else begin
      y_valid <= en;
      if (en) begin
        y <= sel_data;
      end
    end
  end

`ifndef SYNTHESIS
  sel_known_a : assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(sel));
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb/tb_mux_4to1.sv - bench for mux_4to1 at WIDTH 1 and WIDTH 8
// Directed table, reset corners, then random traffic against an arithmetic model.
module tb_mux_4to1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  sel;
  logic [3:0]  d1;
  logic [31:0] d8;
  logic        y1;
  logic        v1;
  logic [7:0]  y8;
  logic        v8;

  int checks;
  int failures;

  logic       exp_y1;
  logic [7:0] exp_y8;
  logic       exp_v;

  localparam logic [7:0] RST8 = 8'h5A;

  mux_4to1 #(.WIDTH(1), .RESET_VAL(64'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .d(d1), .y(y1), .y_valid(v1)
  );

  mux_4to1 #(.WIDTH(8), .RESET_VAL(64'h35A)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .d(d8), .y(y8), .y_valid(v8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic       en;
    logic       y1;
    logic [7:0] y8;
    logic       v;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_y1 = 1'b0;
    exp_y8 = RST8;
    exp_v  = 1'b0;
  endtask

  // advance one edge, updating the reference model from the pre-edge inputs
  task automatic tick();
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_v = en;
      if (en) begin
        exp_y1 = 1'((d1 >> sel) & 4'h1);
        exp_y8 = 8'((d8 >> (8 * sel)) & 32'hFF);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_y1"}, 64'(y1), 64'(exp_y1));
    chk({tag, "_y8"}, 64'(y8), 64'(exp_y8));
    chk({tag, "_v1"}, 64'(v1), 64'(exp_v));
    chk({tag, "_v8"}, 64'(v8), 64'(exp_v));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();

    vecs[0] = '{sel: 2'd0, en: 1'b1, y1: 1'b0, y8: 8'hAA, v: 1'b1};
    vecs[1] = '{sel: 2'd1, en: 1'b1, y1: 1'b1, y8: 8'hBB, v: 1'b1};
    vecs[2] = '{sel: 2'd2, en: 1'b1, y1: 1'b0, y8: 8'hCC, v: 1'b1};
    vecs[3] = '{sel: 2'd3, en: 1'b1, y1: 1'b1, y8: 8'hDD, v: 1'b1};
    vecs[4] = '{sel: 2'd1, en: 1'b1, y1: 1'b1, y8: 8'hBB, v: 1'b1};
    vecs[5] = '{sel: 2'd0, en: 1'b0, y1: 1'b1, y8: 8'hBB, v: 1'b0};
    vecs[6] = '{sel: 2'd0, en: 1'b1, y1: 1'b0, y8: 8'hAA, v: 1'b1};

    // reset held with active-looking inputs
    rst_n = 1'b0;
    en    = 1'b1;
    sel   = 2'b11;
    d1    = 4'b1010;
    d8    = 32'hDDCCBBAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_y1", 64'(y1), 64'h0);
      chk("rst_hold_y8", 64'(y8), 64'(RST8));
      chk("rst_hold_v1", 64'(v1), 64'h0);
      chk("rst_hold_v8", 64'(v8), 64'h0);
    end
    #2;
    rst_n = 1'b1;
    @(negedge clk);

    // directed sweep and enable hold
    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].sel;
      en  = vecs[i].en;
      tick();
      chk($sformatf("vec%0d_y1", i), 64'(y1), 64'(vecs[i].y1));
      chk($sformatf("vec%0d_y8", i), 64'(y8), 64'(vecs[i].y8));
      chk($sformatf("vec%0d_v1", i), 64'(v1), 64'(vecs[i].v));
      chk($sformatf("vec%0d_v8", i), 64'(v8), 64'(vecs[i].v));
    end

    // mid-stream asynchronous reset pulse between edges
    sel = 2'd2;
    en  = 1'b1;
    tick();
    chk("pre_rst_y8", 64'(y8), 64'hCC);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y1", 64'(y1), 64'h0);
    chk("async_rst_y8", 64'(y8), 64'(RST8));
    chk("async_rst_v1", 64'(v1), 64'h0);
    chk("async_rst_v8", 64'(v8), 64'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
    sel   = 2'd3;
    tick();
    chk("resume_y1", 64'(y1), 64'h1);
    chk("resume_y8", 64'(y8), 64'hDD);
    chk("resume_v8", 64'(v8), 64'h1);

    // random traffic
    for (int i = 0; i < 1000; i++) begin
      d1  = 4'($urandom);
      d8  = $urandom;
      sel = 2'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      tick();
      chk_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
